// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side controller placed directly after sync_fifo.
// It issues read_req in bursts and captures read_data into a 2-entry
// output buffer. The buffer drains to the consumer as a valid/ready stream.
// A timeout starts a drain burst when only residual words remain.
//
// Optional feature: define FIFO_RD_STREAM_CHKSUM_EN to build the running
// rotate-xor checksum. Without it, chksum is tied to zero.
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   flush                   synchronous clear (shared with sync_fifo)
//   fifo_empty/fifo_aempty  FIFO status
//   read_req                read strobe to FIFO
//   read_data/rdata_valid   FIFO read return (1-cycle latency)
//   out_data/out_valid      stream head / buffer non-empty
//   out_ready               consumer accept
//   word_count              delivered words (wraps)
//   busy                    FSM active, or buffer/in-flight non-empty
//   err_ovf                 sticky: return word dropped on a full buffer
//   chksum                  running checksum of delivered words
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no reads; timeout counts residual-data cycles
// S_BURST | issue reads while buffer space allows, up to BURST_LEN
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic                  fifo_aempty,
  output logic                  read_req,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  rdata_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           word_count,
  output logic                  busy,
  output logic                  err_ovf,
  output logic [DATA_WIDTH-1:0] chksum
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  localparam logic [3:0] BURST_LAST = 4'(BURST_LEN - 1);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [3:0]            burst_cnt_q, burst_cnt_d;
  logic [7:0]            tmo_cnt_q, tmo_cnt_d;
  logic                  inflight_q, inflight_d;
  logic                  discard_q, discard_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [15:0]           word_count_q, word_count_d;
  logic                  err_ovf_q, err_ovf_d;
  logic                  pop, push, drop;
  logic [2:0]            avail;

  // FSM, counters and read strobe.
  always_comb begin
    pop         = (occ_q != 2'd0) & out_ready;
    // Buffer slots committed after this cycle; the pop frees one now,
    // which is what lets a full buffer resume reads as soon as ready returns.
    avail       = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    read_req    = 1'b0;
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    case (state_q)
      S_IDLE: begin
        burst_cnt_d = '0;
        if (fifo_empty)       tmo_cnt_d = '0;
        else if (fifo_aempty) tmo_cnt_d = tmo_cnt_q + 8'd1;
        // The TIMEOUT-th residual cycle moves to BURST, so the first read
        // lands in cycle TIMEOUT+1.
        if (~fifo_aempty | (~fifo_empty & fifo_aempty & (tmo_cnt_q == TMO_LAST))) begin
          state_d   = S_BURST;
          tmo_cnt_d = '0;
        end
      end
      S_BURST: begin
        read_req = ~fifo_empty & (avail < 3'd2);
        if (read_req) burst_cnt_d = burst_cnt_q + 4'd1;
        if (fifo_empty | (read_req & (burst_cnt_q == BURST_LAST))) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      // A read during flush would target a FIFO that is being cleared.
      read_req    = 1'b0;
      state_d     = S_IDLE;
      burst_cnt_d = '0;
      tmo_cnt_d   = '0;
    end
    inflight_d = read_req & ~fifo_empty;
    discard_d  = flush;
  end

  // Output buffer: buf0 is the head, buf1 the second entry.
  always_comb begin
    push         = rdata_valid & ~discard_q & ((occ_q != 2'd2) | pop);
    drop         = rdata_valid & ~discard_q & (occ_q == 2'd2) & ~pop;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    occ_d        = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = read_data;
        else               buf1_d = read_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = read_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = read_data;
        end
      end
      default: ;
    endcase
    err_ovf_d    = err_ovf_q | drop;
    word_count_d = word_count_q + 16'(pop);
    if (flush) begin
      occ_d        = '0;
      err_ovf_d    = 1'b0;
      word_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      burst_cnt_q  <= '0;
      tmo_cnt_q    <= '0;
      inflight_q   <= 1'b0;
      discard_q    <= 1'b0;
      occ_q        <= '0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      word_count_q <= '0;
      err_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      inflight_q   <= inflight_d;
      discard_q    <= discard_d;
      occ_q        <= occ_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      word_count_q <= word_count_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

`ifdef FIFO_RD_STREAM_CHKSUM_EN
  logic [DATA_WIDTH-1:0] chksum_q, chksum_d;

  always_comb begin
    chksum_d = chksum_q;
    if (flush)    chksum_d = '0;
    else if (pop) chksum_d = {chksum_q[DATA_WIDTH-2:0], chksum_q[DATA_WIDTH-1]} ^ buf0_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) chksum_q <= '0;
    else          chksum_q <= chksum_d;
  end

  assign chksum = chksum_q;
`else
  assign chksum = '0;
`endif

  assign out_data   = buf0_q;
  assign out_valid  = (occ_q != 2'd0);
  assign word_count = word_count_q;
  assign err_ovf    = err_ovf_q;
  assign busy       = (state_q == S_BURST) | (occ_q != 2'd0) | inflight_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;
  localparam int DW = 16, BL = 4, TO = 8, AE_TH = 2;

  logic          clk = 1'b0, reset_n = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic          fifo_empty, fifo_aempty, read_req, rdata_valid;
  logic          out_valid, busy, err_ovf;
  logic [DW-1:0] read_data, out_data, chksum;
  logic [15:0]   word_count;

  int n_cmp = 0, n_err = 0;

  // Behavioural sync_fifo: queue contents, 1-cycle read latency.
  logic [DW-1:0] fq[$];
  int            fcnt = 0;
  logic          m_rv = 1'b0;
  logic [DW-1:0] m_rd = '0;
  logic          inj_v = 1'b0;
  logic [DW-1:0] inj_d = '0;

  assign fifo_empty  = (fcnt == 0);
  assign fifo_aempty = (fcnt <= AE_TH);
  assign rdata_valid = m_rv | inj_v;
  assign read_data   = inj_v ? inj_d : m_rd;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_rv <= 1'b0;
    end else if (flush) begin
      fq.delete();
      m_rv <= 1'b0;
    end else if (read_req && fq.size() > 0) begin
      m_rd <= fq.pop_front();
      m_rv <= 1'b1;
    end else begin
      m_rv <= 1'b0;
    end
    fcnt = fq.size();
  end

  fifo_rd_stream #(.DATA_WIDTH(DW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_aempty(fifo_aempty),
    .read_req(read_req), .read_data(read_data), .rdata_valid(rdata_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .word_count(word_count), .busy(busy), .err_ovf(err_ovf), .chksum(chksum)
  );

  // Per-cycle observation: popped words, read strobes, read runs and gaps.
  logic [DW-1:0] got[$];
  int rd_cnt, run_len, gap, rd_empty_viol;
  int runs[$];
  int gaps[$];

  task automatic clear_trk();
    got.delete(); runs.delete(); gaps.delete();
    rd_cnt = 0; run_len = 0; gap = 0; rd_empty_viol = 0;
  endtask

  // Called at a negedge with inputs already applied; returns at next negedge.
  task automatic step();
    #1;
    if (out_valid && out_ready) got.push_back(out_data);
    if (read_req) begin
      rd_cnt++;
      if (fifo_empty) rd_empty_viol++;
      if (run_len == 0) gaps.push_back(gap);
      run_len++;
      gap = 0;
    end else if (run_len > 0) begin
      runs.push_back(run_len);
      run_len = 0;
      gap = 1;
    end else begin
      gap++;
    end
    @(negedge clk);
  endtask

  task automatic preload(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) fq.push_back(base + DW'(i));
    fcnt = fq.size();
  endtask

  task automatic do_flush();
    inj_v = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    clear_trk();
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({read_req, out_valid, busy, err_ovf} !== 4'b0 || out_data !== '0 ||
        word_count !== '0 || chksum !== '0) begin
      n_err++;
      $display("FAIL reset: rr=%b ov=%b busy=%b ovf=%b data=%h wc=%h ck=%h required all zero",
               read_req, out_valid, busy, err_ovf, out_data, word_count, chksum);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_burst_drain();
    do_flush();
    out_ready = 1'b1;
    preload(10, 16'h0001);
    for (int c = 0; c < 80 && got.size() < 10; c++) step();
    n_cmp++;
    if (got.size() != 10) begin
      n_err++; $display("FAIL burst_count: got %0d words required 10", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== DW'(i + 1)) begin
        n_err++; $display("FAIL burst_order[%0d]: got %h required %h", i, got[i], i + 1);
      end
    end
    n_cmp++;
    if (runs.size() != 3 || runs[0] != 4 || runs[1] != 4 || runs[2] != 2) begin
      n_err++; $display("FAIL burst_runs: got %0d runs (%p) required 4,4,2", runs.size(), runs);
    end
    n_cmp++;
    if (gaps.size() != 3 || gaps[1] != 1 || gaps[2] != TO) begin
      n_err++; $display("FAIL burst_gaps: got %p required gap1=1 gap2=%0d", gaps, TO);
    end
    n_cmp++;
    if (word_count !== 16'd10 || err_ovf !== 1'b0) begin
      n_err++; $display("FAIL burst_status: wc=%0d ovf=%b required 10/0", word_count, err_ovf);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    bit seen, stable;
    do_flush();
    out_ready = 1'b0;
    preload(6, 16'h0100);
    seen = 0; stable = 1; held = '0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (out_valid) begin
        if (seen && out_data !== held) stable = 0;
        held = out_data; seen = 1;
      end
    end
    n_cmp++;
    if (rd_cnt != 2) begin
      n_err++; $display("FAIL hold_reads: got %0d reads required 2", rd_cnt);
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 16'h0100 || !stable) begin
      n_err++; $display("FAIL hold_head: ov=%b data=%h stable=%0d required 1/0100/1",
                        out_valid, out_data, stable);
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (read_req !== 1'b1) begin
      n_err++; $display("FAIL hold_resume: read_req=%b required 1", read_req);
    end
    for (int c = 0; c < 60 && got.size() < 6; c++) step();
    n_cmp++;
    if (got.size() != 6) begin
      n_err++; $display("FAIL hold_count: got %0d words required 6", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== 16'h0100 + DW'(i)) begin
        n_err++; $display("FAIL hold_order[%0d]: got %h required %h", i, got[i], 16'h0100 + i);
      end
    end
  endtask

  task automatic test_timeout();
    do_flush();
    out_ready = 1'b1;
    preload(2, 16'h0200);
    for (int c = 1; c <= 9; c++) begin
      #1;
      n_cmp++;
      if (read_req !== (c == 9)) begin
        n_err++; $display("FAIL timeout_cycle%0d: read_req=%b required %b", c, read_req, c == 9);
      end
      step();
    end
    for (int c = 0; c < 20 && got.size() < 2; c++) step();
    n_cmp++;
    if (got.size() != 2 || got[0] !== 16'h0200 || got[1] !== 16'h0201) begin
      n_err++; $display("FAIL timeout_words: got %p required 0200,0201", got);
    end
  endtask

  task automatic test_flush();
    bit found, prev;
    do_flush();
    out_ready = 1'b1;
    preload(6, 16'h0300);
    found = 0; prev = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (prev && word_count != 0) begin found = 1; break; end
      prev = read_req;
      step();
    end
    n_cmp++;
    if (!found) begin
      n_err++; $display("FAIL flush_setup: in-flight read with delivered words not seen, required seen");
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    inj_v = 1'b1; inj_d = 16'hBEEF;
    step();
    inj_v = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || word_count !== 16'd0 || busy !== 1'b0 || err_ovf !== 1'b0) begin
      n_err++; $display("FAIL flush_clear: ov=%b wc=%0d busy=%b ovf=%b required 0/0/0/0",
                        out_valid, word_count, busy, err_ovf);
    end
  endtask

  task automatic test_overflow();
    do_flush();
    out_ready = 1'b0;
    inj_v = 1'b1; inj_d = 16'hA000; step();
    inj_d = 16'hB000; step();
    n_cmp++;
    if (err_ovf !== 1'b0 || out_data !== 16'hA000) begin
      n_err++; $display("FAIL ovf_full: ovf=%b data=%h required 0/A000", err_ovf, out_data);
    end
    out_ready = 1'b1; inj_d = 16'hC000; step();
    n_cmp++;
    if (err_ovf !== 1'b0) begin
      n_err++; $display("FAIL ovf_pushpop: ovf=%b required 0", err_ovf);
    end
    out_ready = 1'b0; inj_d = 16'hD000; step();
    inj_v = 1'b0;
    for (int c = 0; c < 3; c++) step();
    n_cmp++;
    if (err_ovf !== 1'b1 || out_data !== 16'hB000) begin
      n_err++; $display("FAIL ovf_set: ovf=%b data=%h required 1/B000", err_ovf, out_data);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();
    n_cmp++;
    if (got.size() != 3 || got[0] !== 16'hA000 || got[1] !== 16'hB000 || got[2] !== 16'hC000) begin
      n_err++; $display("FAIL ovf_words: got %p required A000,B000,C000", got);
    end
    n_cmp++;
    if (err_ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_sticky: ovf=%b required 1", err_ovf);
    end
    do_flush();
    n_cmp++;
    if (err_ovf !== 1'b0) begin
      n_err++; $display("FAIL ovf_flush: ovf=%b required 0", err_ovf);
    end
  endtask

  task automatic test_chksum();
    logic [DW-1:0] exp_ck;
    do_flush();
    out_ready = 1'b1;
    inj_v = 1'b1; inj_d = 16'h0001; step();
    inj_d = 16'h0002; step();
    inj_d = 16'h0004; step();
    inj_v = 1'b0;
    for (int c = 0; c < 3; c++) step();
`ifdef FIFO_RD_STREAM_CHKSUM_EN
    exp_ck = 16'h0004;
`else
    exp_ck = 16'h0000;
`endif
    n_cmp++;
    if (got.size() != 3 || chksum !== exp_ck) begin
      n_err++; $display("FAIL chksum: words=%0d chksum=%h required 3/%h", got.size(), chksum, exp_ck);
    end
  endtask

  task automatic test_async_reset();
    do_flush();
    out_ready = 1'b0;
    preload(6, 16'h0500);
    for (int c = 0; c < 4; c++) step();
    n_cmp++;
    if (busy !== 1'b1 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL areset_pre: busy=%b ov=%b required 1/1", busy, out_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || read_req !== 1'b0 || out_data !== '0) begin
      n_err++; $display("FAIL areset_now: busy=%b ov=%b rr=%b data=%h required 0/0/0/0",
                        busy, out_valid, read_req, out_data);
    end
    fq.delete(); fcnt = 0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    step();
    inj_v = 1'b1; inj_d = 16'h5A5A; step();
    inj_v = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 16'h5A5A) begin
      n_err++; $display("FAIL areset_nodiscard: ov=%b data=%h required 1/5A5A", out_valid, out_data);
    end
    out_ready = 1'b1;
    step(); step();
  endtask

  task automatic test_random();
    logic [DW-1:0] ex[$];
    logic [DW-1:0] w, ck;
    int total, bad_runs, nw;
    do_flush();
    total = 0; ck = '0;
    for (int c = 0; c < 700; c++) begin
      if (c < 400 && $urandom_range(0, 3) == 0) begin
        nw = $urandom_range(1, 3);
        for (int k = 0; k < nw; k++) begin
          w = DW'($urandom);
          fq.push_back(w); ex.push_back(w);
        end
        fcnt = fq.size();
      end
      out_ready = (c >= 400) || ($urandom_range(0, 3) != 0);
      step();
      while (got.size() > 0) begin
        w = got.pop_front();
        n_cmp++;
        if (ex.size() == 0) begin
          n_err++; $display("FAIL rand_extra: got %h required none", w);
        end else begin
          if (w !== ex[0]) begin
            n_err++; $display("FAIL rand_word%0d: got %h required %h", total, w, ex[0]);
          end
          void'(ex.pop_front());
        end
        total++;
        ck = {ck[DW-2:0], ck[DW-1]} ^ w;
      end
      if (c >= 400 && ex.size() == 0 && fq.size() == 0) break;
    end
    n_cmp++;
    if (ex.size() != 0) begin
      n_err++; $display("FAIL rand_drain: %0d words left required 0", ex.size());
    end
    n_cmp++;
    if (word_count !== 16'(total) || err_ovf !== 1'b0) begin
      n_err++; $display("FAIL rand_status: wc=%0d ovf=%b required %0d/0", word_count, err_ovf, total);
    end
    bad_runs = 0;
    foreach (runs[i]) if (runs[i] > BL) bad_runs++;
    n_cmp++;
    if (bad_runs != 0 || rd_empty_viol != 0) begin
      n_err++; $display("FAIL rand_reads: long runs=%0d reads on empty=%0d required 0/0",
                        bad_runs, rd_empty_viol);
    end
`ifndef FIFO_RD_STREAM_CHKSUM_EN
    ck = '0;
`endif
    n_cmp++;
    if (chksum !== ck) begin
      n_err++; $display("FAIL rand_chksum: got %h required %h", chksum, ck);
    end
  endtask

  initial begin
    clear_trk();
    test_reset();
    test_burst_drain();
    test_backpressure();
    test_timeout();
    test_flush();
    test_overflow();
    test_chksum();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
